// File: rtl/sync_cp_strip.sv
// Cyclic-prefix removal: drops the CP of each OFDM symbol and forwards fft_size useful
// samples per symbol with sop/eop framing, one clock of latency.
module sync_cp_strip #(
  parameter int unsigned pDAT_W    = 12,
  parameter int unsigned pSYM_Num  = 14,
  parameter int unsigned pSYM_Slot = 7
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iena,
  input  logic [7:0]        imode,
  input  logic              isop,
  input  logic              ival,
  input  logic [pDAT_W-1:0] idata_I,
  input  logic [pDAT_W-1:0] idata_Q,
  output logic              oreq_data,
  output logic              oval,
  output logic              osop,
  output logic              oeop,
  output logic [pDAT_W-1:0] odata_I,
  output logic [pDAT_W-1:0] odata_Q,
  output logic [3:0]        osym_idx,
  output logic              ofrm_done,
  output logic              oerr
);

  localparam logic [3:0] SymLast  = 4'(pSYM_Num - 1);
  localparam logic [3:0] SlotLast = 4'(pSYM_Slot - 1);

  typedef enum logic [1:0] {StIdle, StCp, StData, StDone} state_e;

  state_e      state_q;
  logic [10:0] n_q;
  logic [10:0] cp_cnt_q;
  logic [10:0] cp_len_q;
  logic [10:0] dat_cnt_q;
  logic [3:0]  sym_idx_q;
  logic [3:0]  slot_q;

  logic        acc;
  logic        restart;
  logic        dat_last;
  logic [10:0] n_new;
  logic [3:0]  slot_nxt;

  function automatic logic [10:0] mode_to_n(input logic [7:0] m);
    case (m)
      8'd1:    return 11'd128;
      8'd2:    return 11'd256;
      8'd3:    return 11'd512;
      default: return 11'd1024;
    endcase
  endfunction

  // Long CP = N*5/64, short CP = N*9/128, both exact for power-of-two N >= 128.
  function automatic logic [10:0] cp_of(input logic [10:0] n, input logic long_cp);
    return long_cp ? 11'((n >> 4) + (n >> 6)) : 11'((n >> 4) + (n >> 7));
  endfunction

  assign acc      = iena & ival;
  assign restart  = acc & isop;
  assign n_new    = mode_to_n(imode);
  assign dat_last = (dat_cnt_q == 11'(n_q - 11'd1));
  assign slot_nxt = (slot_q == SlotLast) ? 4'd0 : 4'(slot_q + 4'd1);

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state_q   <= StIdle;
      n_q       <= 11'd1024;
      cp_cnt_q  <= '0;
      cp_len_q  <= '0;
      dat_cnt_q <= '0;
      sym_idx_q <= '0;
      slot_q    <= '0;
      oreq_data <= 1'b0;
      oval      <= 1'b0;
      osop      <= 1'b0;
      oeop      <= 1'b0;
      odata_I   <= '0;
      odata_Q   <= '0;
      osym_idx  <= '0;
      ofrm_done <= 1'b0;
      oerr      <= 1'b0;
    end else begin
      // Pulse outputs default low; with iena low nothing below sets them.
      oval      <= 1'b0;
      osop      <= 1'b0;
      oeop      <= 1'b0;
      ofrm_done <= 1'b0;
      oerr      <= 1'b0;
      if (iena) begin
        oreq_data <= (state_q == StIdle);
        if (restart) begin
          n_q       <= n_new;
          sym_idx_q <= '0;
          slot_q    <= '0;
          cp_len_q  <= cp_of(n_new, 1'b1);
          cp_cnt_q  <= 11'd1;
          state_q   <= StCp;
          oerr      <= (state_q != StIdle);
        end else begin
          case (state_q)
            StIdle: ;
            StCp: begin
              if (acc) begin
                if (11'(cp_cnt_q + 11'd1) == cp_len_q) begin
                  dat_cnt_q <= '0;
                  state_q   <= StData;
                end else begin
                  cp_cnt_q <= 11'(cp_cnt_q + 11'd1);
                end
              end
            end
            StData: begin
              if (acc) begin
                oval     <= 1'b1;
                osop     <= (dat_cnt_q == 11'd0);
                oeop     <= dat_last;
                odata_I  <= idata_I;
                odata_Q  <= idata_Q;
                osym_idx <= sym_idx_q;
                if (dat_last) begin
                  if (sym_idx_q == SymLast) begin
                    state_q <= StDone;
                  end else begin
                    sym_idx_q <= 4'(sym_idx_q + 4'd1);
                    slot_q    <= slot_nxt;
                    cp_len_q  <= cp_of(n_q, slot_nxt == 4'd0);
                    cp_cnt_q  <= '0;
                    state_q   <= StCp;
                  end
                end else begin
                  dat_cnt_q <= 11'(dat_cnt_q + 11'd1);
                end
              end
            end
            StDone: begin
              ofrm_done <= 1'b1;
              state_q   <= StIdle;
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_cp_strip.sv
// Directed bench for sync_cp_strip: ramp-valued replays checked against a CP-layout model.
module tb_sync_cp_strip;

  localparam int W = 16;  // wide enough to carry the full 15360-sample ramp

  logic         iclk = 1'b0;
  logic         ireset;
  logic         iena;
  logic [7:0]   imode;
  logic         isop;
  logic         ival;
  logic [W-1:0] idata_I;
  logic [W-1:0] idata_Q;
  logic         oreq_data;
  logic         oval;
  logic         osop;
  logic         oeop;
  logic [W-1:0] odata_I;
  logic [W-1:0] odata_Q;
  logic [3:0]   osym_idx;
  logic         ofrm_done;
  logic         oerr;

  int total = 0;
  int bad   = 0;

  int q_data[$];
  int q_qd[$];
  int q_sym[$];
  int q_sop[$];
  int q_eop[$];
  int q_cyc[$];
  int done_cyc[$];
  int err_cyc[$];
  int cyc       = 0;
  int req_rises = 0;
  int en_bad    = 0;
  int qual_bad  = 0;
  logic req_prev = 1'b0;
  logic en_prev  = 1'b1;

  sync_cp_strip #(
    .pDAT_W   (W),
    .pSYM_Num (14),
    .pSYM_Slot(7)
  ) dut (
    .iclk     (iclk),
    .ireset   (ireset),
    .iena     (iena),
    .imode    (imode),
    .isop     (isop),
    .ival     (ival),
    .idata_I  (idata_I),
    .idata_Q  (idata_Q),
    .oreq_data(oreq_data),
    .oval     (oval),
    .osop     (osop),
    .oeop     (oeop),
    .odata_I  (odata_I),
    .odata_Q  (odata_Q),
    .osym_idx (osym_idx),
    .ofrm_done(ofrm_done),
    .oerr     (oerr)
  );

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc++;

  always @(negedge iclk) begin
    if (oval) begin
      q_data.push_back(int'(odata_I));
      q_qd.push_back(int'(odata_Q));
      q_sym.push_back(int'(osym_idx));
      q_sop.push_back(int'(osop));
      q_eop.push_back(int'(oeop));
      q_cyc.push_back(cyc);
    end
    if ((osop || oeop) && !oval) qual_bad++;
    if (!iena && !en_prev && (oval || osop || oeop || ofrm_done || oerr)) en_bad++;
    if (ofrm_done) done_cyc.push_back(cyc);
    if (oerr) err_cyc.push_back(cyc);
    if (oreq_data && !req_prev) req_rises++;
    req_prev = oreq_data;
    en_prev  = iena;
  end

  // Offset (from the sop sample) of the first useful sample of symbol s.
  function automatic int sym_start(int n, int s);
    int acc;
    acc = 0;
    for (int t = 0; t <= s; t++) begin
      acc += ((t % 7) == 0) ? (n * 5 / 64) : (n * 9 / 128);
      if (t < s) acc += n;
    end
    return acc;
  endfunction

  // Index of the first captured output disagreeing with the model, or -1.
  function automatic int first_bad(int start, int cnt, int n, int base);
    int idx, s, j, v;
    for (int k = 0; k < cnt; k++) begin
      idx = start + k;
      s   = k / n;
      j   = k % n;
      v   = base + sym_start(n, s) + j;
      if (idx >= q_data.size()) return idx;
      if (q_data[idx] != v || q_qd[idx] != (~v & 32'hffff) || q_sym[idx] != s ||
          q_sop[idx] != int'(j == 0) || q_eop[idx] != int'(j == n - 1)) return idx;
    end
    return -1;
  endfunction

  task automatic clear_q();
    q_data.delete(); q_qd.delete(); q_sym.delete(); q_sop.delete(); q_eop.delete();
    q_cyc.delete(); done_cyc.delete(); err_cyc.delete();
    en_bad = 0; qual_bad = 0;
  endtask

  task automatic drive(input logic sop, input logic val, input int d);
    isop    = sop;
    ival    = val;
    idata_I = d[W-1:0];
    idata_Q = ~d[W-1:0];
    @(posedge iclk);
    #1;
  endtask

  task automatic stream(input int n, input int vld_pct, input int resync_at, input int mode_at,
                        input logic [7:0] mode_new, input int en_at);
    for (int i = 0; i < n; i++) begin
      if (i == mode_at) imode = mode_new;
      if (i == en_at) begin
        iena = 1'b0;
        for (int c = 0; c < 50; c++) drive(1'b1, 1'b1, 16'h0bad);
        iena = 1'b1;
      end
      if (vld_pct < 100) while ($urandom_range(0, 99) >= vld_pct) drive(1'b0, 1'b0, 0);
      drive(i == 0 || i == resync_at, 1'b1, i);
    end
    repeat (6) drive(1'b0, 1'b0, 0);
  endtask

  task automatic test_reset();
    logic [41:0] outs;
    ireset = 1'b0; iena = 1'b1; imode = 8'd1; isop = 1'b0; ival = 1'b0;
    idata_I = '0; idata_Q = '0;
    repeat (3) @(negedge iclk);
    outs = {oval, osop, oeop, oreq_data, ofrm_done, oerr, osym_idx, odata_I, odata_Q};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_outs: got %h expected 0", outs); end
    ireset = 1'b1;
    #1;
    total++;
    if (oreq_data !== 1'b0) begin bad++; $display("FAIL req_before_edge: got %b expected 0", oreq_data); end
    @(negedge iclk);
    total++;
    if (oreq_data !== 1'b1) begin bad++; $display("FAIL req_after_edge: got %b expected 1", oreq_data); end
    @(posedge iclk);
    #1;
  endtask

  task automatic test_mode1();
    int r0, fb;
    clear_q(); r0 = req_rises; imode = 8'd1;
    stream(1920, 100, -1, -1, 8'd0, -1);
    fb = first_bad(0, 1792, 128, 0);
    total++; if (q_data.size() != 1792) begin bad++; $display("FAIL m1_count: got %0d expected 1792", q_data.size()); end
    total++; if (fb != -1) begin bad++; $display("FAIL m1_seq: first bad index %0d expected none", fb); end
    total++; if (q_data[0] != 10) begin bad++; $display("FAIL m1_sym0_first: got %0d expected 10", q_data[0]); end
    total++; if (q_data[128] != 147 || q_data[255] != 274) begin
      bad++; $display("FAIL m1_sym1: got %0d..%0d expected 147..274", q_data[128], q_data[255]);
    end
    total++; if (done_cyc.size() != 1 || done_cyc[0] != q_cyc[q_cyc.size()-1] + 1) begin
      bad++; $display("FAIL m1_done: got %0d pulses at %0d expected 1 at %0d", done_cyc.size(),
                      done_cyc[0], q_cyc[q_cyc.size()-1] + 1);
    end
    total++; if (req_rises - r0 != 1) begin bad++; $display("FAIL m1_req: got %0d rises expected 1", req_rises - r0); end
    total++; if (err_cyc.size() != 0 || qual_bad != 0) begin
      bad++; $display("FAIL m1_err_qual: got err=%0d qual=%0d expected 0/0", err_cyc.size(), qual_bad);
    end
  endtask

  task automatic test_mode4();
    int fb;
    clear_q(); imode = 8'd4;
    stream(15360, 100, -1, -1, 8'd0, -1);
    fb = first_bad(0, 14336, 1024, 0);
    total++; if (q_data.size() != 14336) begin bad++; $display("FAIL m4_count: got %0d expected 14336", q_data.size()); end
    total++; if (fb != -1) begin bad++; $display("FAIL m4_seq: first bad index %0d expected none", fb); end
    total++; if (q_data[7168] != 7760 || q_data[8191] != 8783) begin
      bad++; $display("FAIL m4_sym7: got %0d..%0d expected 7760..8783", q_data[7168], q_data[8191]);
    end
    total++; if (done_cyc.size() != 1) begin bad++; $display("FAIL m4_done: got %0d expected 1", done_cyc.size()); end
  endtask

  task automatic test_gaps();
    int fb;
    clear_q(); imode = 8'd2;
    stream(3840, 50, -1, -1, 8'd0, -1);
    fb = first_bad(0, 3584, 256, 0);
    total++; if (q_data.size() != 3584) begin bad++; $display("FAIL gap_count: got %0d expected 3584", q_data.size()); end
    total++; if (fb != -1) begin bad++; $display("FAIL gap_seq: first bad index %0d expected none", fb); end
    total++; if (done_cyc.size() != 1) begin bad++; $display("FAIL gap_done: got %0d expected 1", done_cyc.size()); end
  endtask

  task automatic test_resync();
    int fb1, fb2, eops;
    clear_q(); imode = 8'd1;
    stream(2420, 100, 500, -1, 8'd0, -1);
    // Before the resync: symbols 0..2 complete plus 79 samples (421..499) of symbol 3.
    fb1 = first_bad(0, 463, 128, 0);
    fb2 = first_bad(463, 1792, 128, 500);
    eops = 0;
    for (int k = 0; k < 463 && k < q_eop.size(); k++) eops += q_eop[k];
    total++; if (err_cyc.size() != 1) begin bad++; $display("FAIL rs_err: got %0d pulses expected 1", err_cyc.size()); end
    total++; if (eops != 3) begin bad++; $display("FAIL rs_no_eop: got %0d eops expected 3", eops); end
    total++; if (q_data[463] != 510 || q_sym[463] != 0 || q_sop[463] != 1) begin
      bad++; $display("FAIL rs_resume: got val=%0d sym=%0d sop=%0d expected 510/0/1",
                      q_data[463], q_sym[463], q_sop[463]);
    end
    total++; if (fb1 != -1 || fb2 != -1 || q_data.size() != 2255) begin
      bad++; $display("FAIL rs_seq: got bad=%0d/%0d size=%0d expected -1/-1/2255", fb1, fb2, q_data.size());
    end
  endtask

  task automatic test_mode_change();
    int fb;
    clear_q(); imode = 8'd1;
    stream(1920, 100, -1, 300, 8'd3, -1);
    fb = first_bad(0, 1792, 128, 0);
    total++; if (fb != -1 || q_data.size() != 1792) begin
      bad++; $display("FAIL mc_first: got bad=%0d size=%0d expected -1/1792", fb, q_data.size());
    end
    clear_q();
    stream(7680, 100, -1, -1, 8'd0, -1);
    fb = first_bad(0, 7168, 512, 0);
    total++; if (q_data[0] != 40 || q_data[512] != 588) begin
      bad++; $display("FAIL mc_cp512: got %0d/%0d expected 40/588", q_data[0], q_data[512]);
    end
    total++; if (fb != -1 || q_data.size() != 7168) begin
      bad++; $display("FAIL mc_second: got bad=%0d size=%0d expected -1/7168", fb, q_data.size());
    end
  endtask

  task automatic test_enable();
    int fb;
    clear_q(); imode = 8'd1;
    stream(1920, 100, -1, -1, 8'd0, 3);
    fb = first_bad(0, 1792, 128, 0);
    total++; if (fb != -1 || q_data.size() != 1792) begin
      bad++; $display("FAIL en_seq: got bad=%0d size=%0d expected -1/1792", fb, q_data.size());
    end
    total++; if (en_bad != 0 || err_cyc.size() != 0) begin
      bad++; $display("FAIL en_frozen: got en_bad=%0d err=%0d expected 0/0", en_bad, err_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [41:0] outs;
    int r0, fb;
    clear_q(); imode = 8'd1;
    drive(1'b1, 1'b1, 0);
    for (int i = 1; i < 200; i++) drive(1'b0, 1'b1, i);
    total++; if (oval !== 1'b1) begin bad++; $display("FAIL rm_active: got oval=%b expected 1", oval); end
    r0 = req_rises;
    ireset = 1'b0;
    #1;
    outs = {oval, osop, oeop, oreq_data, ofrm_done, oerr, osym_idx, odata_I, odata_Q};
    total++; if (outs !== '0) begin bad++; $display("FAIL rm_outs: got %h expected 0", outs); end
    @(negedge iclk);
    ireset = 1'b1;
    @(posedge iclk);
    #1;
    clear_q();
    for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, i);
    total++; if (q_data.size() != 0) begin bad++; $display("FAIL rm_idle: got %0d outputs expected 0", q_data.size()); end
    total++; if (req_rises - r0 != 1) begin bad++; $display("FAIL rm_req: got %0d rises expected 1", req_rises - r0); end
    stream(1920, 100, -1, -1, 8'd0, -1);
    fb = first_bad(0, 1792, 128, 0);
    total++; if (fb != -1 || q_data.size() != 1792) begin
      bad++; $display("FAIL rm_after: got bad=%0d size=%0d expected -1/1792", fb, q_data.size());
    end
  endtask

  initial begin
    test_reset();
    test_mode1();
    test_mode4();
    test_gaps();
    test_resync();
    test_mode_change();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
